// File: rtl/axi_console_capture.sv
// Snoops the 128-bit AXI write path and turns single-beat console writes into a character stream.
// Optional test-exit decode is enabled by defining AXI_CONSOLE_EXIT_EN.
module axi_console_capture #(
    parameter logic [31:0] CONSOLE_ADDR = 32'h01ff_fff0,
    parameter logic [31:0] EXIT_ADDR    = 32'h01ff_ffe0,
    parameter int          CHR_DEPTH    = 16,
    parameter int          AWQ_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         awvalid,
    input  logic                         awready,
    input  logic [31:0]                  awaddr,
    input  logic [3:0]                   awlen,
    input  logic                         wvalid,
    input  logic                         wready,
    input  logic                         wlast,
    input  logic [127:0]                 wdata,
    input  logic [15:0]                  wstrb,
    output logic                         chr_valid,
    output logic [7:0]                   chr_data,
    input  logic                         chr_ready,
    output logic [$clog2(CHR_DEPTH):0]   chr_level,
    output logic [15:0]                  drop_cnt,
    output logic                         proto_err,
    output logic                         test_done,
    output logic                         test_pass
);
    localparam int CAW = $clog2(CHR_DEPTH);
    localparam int AAW = $clog2(AWQ_DEPTH);
`ifdef AXI_CONSOLE_EXIT_EN
    localparam int TW = 2;
`else
    localparam int TW = 1;
`endif

    // Tag bit 0: console hit; bit 1 (exit build only): exit hit.
    logic [TW-1:0] awq_mem [AWQ_DEPTH];
    logic [AAW:0]  awq_wr_q, awq_wr_d, awq_rd_q, awq_rd_d;
    logic [7:0]    chr_mem [CHR_DEPTH];
    logic [CAW:0]  chr_wr_q, chr_wr_d, chr_rd_q, chr_rd_d;
    logic [15:0]   drop_q, drop_d;
    logic          perr_q, perr_d;

    logic          aw_hs, w_hs, awq_empty, awq_full;
    logic          beat_ok, bypass, awq_push, awq_pop, awq_ovf;
    logic [TW-1:0] aw_tag, head_tag, beat_tag;
    logic          lane_hit, chr_in, chr_pop, chr_push, chr_drop, chr_empty, chr_full;
    logic [7:0]    lane_byte;
    logic          unused_bits;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    assign aw_tag[0] = (awaddr[31:4] == CONSOLE_ADDR[31:4]) && (awlen == 4'd0);
`ifdef AXI_CONSOLE_EXIT_EN
    assign aw_tag[1] = (awaddr[31:4] == EXIT_ADDR[31:4]) && (awlen == 4'd0);
`endif

    assign awq_empty = (awq_wr_q == awq_rd_q);
    assign awq_full  = (awq_wr_q[AAW] != awq_rd_q[AAW]) &&
                       (awq_wr_q[AAW-1:0] == awq_rd_q[AAW-1:0]);
    assign head_tag  = awq_mem[awq_rd_q[AAW-1:0]];

    // An empty queue lets a same-cycle AW tag flow straight to its first W beat.
    always_comb begin
        beat_ok  = w_hs && (!awq_empty || aw_hs);
        bypass   = w_hs && awq_empty && aw_hs;
        beat_tag = awq_empty ? aw_tag : head_tag;
        awq_pop  = w_hs && wlast && !awq_empty;
        awq_push = aw_hs && !(bypass && wlast);
        awq_ovf  = awq_push && awq_full && !awq_pop;
        awq_wr_d = (awq_push && !awq_ovf) ? awq_wr_q + (AAW+1)'(1) : awq_wr_q;
        awq_rd_d = awq_pop ? awq_rd_q + (AAW+1)'(1) : awq_rd_q;
        perr_d   = perr_q | (w_hs && !beat_ok) | awq_ovf;
    end

    always_comb begin
        lane_hit  = 1'b1;
        lane_byte = 8'h00;
        case (wstrb)
            16'h000f: lane_byte = wdata[7:0];
            16'h00f0: lane_byte = wdata[39:32];
            16'h0f00: lane_byte = wdata[71:64];
            16'hf000: lane_byte = wdata[103:96];
            default:  lane_hit  = 1'b0;
        endcase
    end

    assign chr_empty = (chr_wr_q == chr_rd_q);
    assign chr_full  = (chr_wr_q[CAW] != chr_rd_q[CAW]) &&
                       (chr_wr_q[CAW-1:0] == chr_rd_q[CAW-1:0]);

    always_comb begin
        chr_in   = beat_ok && beat_tag[0] && lane_hit;
        chr_pop  = !chr_empty && chr_ready;
        chr_push = chr_in && (!chr_full || chr_pop);
        chr_drop = chr_in && chr_full && !chr_pop;
        chr_wr_d = chr_push ? chr_wr_q + (CAW+1)'(1) : chr_wr_q;
        chr_rd_d = chr_pop ? chr_rd_q + (CAW+1)'(1) : chr_rd_q;
        drop_d   = (chr_drop && drop_q != 16'hffff) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (awq_push && !awq_ovf) awq_mem[awq_wr_q[AAW-1:0]] <= aw_tag;
        if (chr_push)             chr_mem[chr_wr_q[CAW-1:0]] <= lane_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awq_wr_q <= '0;
            awq_rd_q <= '0;
            chr_wr_q <= '0;
            chr_rd_q <= '0;
            drop_q   <= '0;
            perr_q   <= 1'b0;
        end else begin
            awq_wr_q <= awq_wr_d;
            awq_rd_q <= awq_rd_d;
            chr_wr_q <= chr_wr_d;
            chr_rd_q <= chr_rd_d;
            drop_q   <= drop_d;
            perr_q   <= perr_d;
        end
    end

    assign chr_valid = !chr_empty;
    assign chr_data  = chr_empty ? 8'h00 : chr_mem[chr_rd_q[CAW-1:0]];
    assign chr_level = chr_wr_q - chr_rd_q;
    assign drop_cnt  = drop_q;
    assign proto_err = perr_q;

`ifdef AXI_CONSOLE_EXIT_EN
    localparam logic [63:0] EXIT_PASS = 64'h0000_0004_4433_3222;
    localparam logic [63:0] EXIT_FAIL = 64'h0000_0023_8234_8720;
    logic        done_q, done_d, pass_q, pass_d, exit_strb;
    logic [63:0] exit_val;

    // Only the first recognised exit value latches; everything later is ignored.
    always_comb begin
        exit_strb = (wstrb == 16'h00ff) || (wstrb == 16'hff00);
        exit_val  = (wstrb == 16'h00ff) ? wdata[63:0] : wdata[127:64];
        done_d    = done_q;
        pass_d    = pass_q;
        if (beat_ok && beat_tag[1] && exit_strb && !done_q) begin
            if (exit_val == EXIT_PASS) begin
                done_d = 1'b1;
                pass_d = 1'b1;
            end else if (exit_val == EXIT_FAIL) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign test_done = done_q;
    assign test_pass = pass_q;
`else
    assign test_done = 1'b0;
    assign test_pass = 1'b0;
`endif

    assign unused_bits = ^{wdata, awaddr[3:0], bypass};
endmodule

// File: tb/tb_axi_console_capture.sv
// Randomised and directed bench for axi_console_capture against a queue-based reference model.
// Build with AXI_CONSOLE_EXIT_EN defined to exercise the exit decode.
module tb_axi_console_capture;
    localparam logic [31:0] CON  = 32'h01ff_fff0;
    localparam logic [31:0] EXT  = 32'h01ff_ffe0;
    localparam logic [31:0] OTH  = 32'h8000_0000;
    localparam logic [63:0] PASS_V = 64'h444333222;
    localparam logic [63:0] FAIL_V = 64'h2382348720;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         awvalid = 0, awready = 0, wvalid = 0, wready = 0, wlast = 0, chr_ready = 0;
    logic [31:0]  awaddr = 0;
    logic [3:0]   awlen = 0;
    logic [127:0] wdata = 0;
    logic [15:0]  wstrb = 0;
    logic         chr_valid, proto_err, test_done, test_pass;
    logic [7:0]   chr_data;
    logic [4:0]   chr_level;
    logic [15:0]  drop_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    logic [1:0]  tagq[$];
    logic [7:0]  chrq[$];
    int          m_drop;
    bit          m_perr, m_done, m_pass;

    always #5 clk = ~clk;

    axi_console_capture dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
        .chr_valid(chr_valid), .chr_data(chr_data), .chr_ready(chr_ready),
        .chr_level(chr_level), .drop_cnt(drop_cnt), .proto_err(proto_err),
        .test_done(test_done), .test_pass(test_pass)
    );

    task automatic model_clear();
        tagq.delete();
        chrq.delete();
        m_drop = 0;
        m_perr = 0;
        m_done = 0;
        m_pass = 0;
    endtask

    // Applies the write-path rules to whatever is currently driven, as of the coming edge.
    task automatic model_edge();
        bit         aw_h, w_h, have, byp, consumed;
        logic [1:0] new_tag, tag;
        int         lane;
        logic [63:0] v;
        aw_h = awvalid && awready;
        w_h  = wvalid && wready;
        have = 0; byp = 0; consumed = 0; tag = 0;
        new_tag[0] = ((awaddr >> 4) == (CON >> 4)) && (awlen == 0);
        new_tag[1] = ((awaddr >> 4) == (EXT >> 4)) && (awlen == 0);
        if (chr_ready && chrq.size() > 0) void'(chrq.pop_front());
        if (w_h) begin
            if (tagq.size() > 0) begin tag = tagq[0]; have = 1; end
            else if (aw_h) begin tag = new_tag; have = 1; byp = 1; end
            else m_perr = 1;
            if (have) begin
                lane = -1;
                if (wstrb == 16'h000f) lane = 0;
                if (wstrb == 16'h00f0) lane = 1;
                if (wstrb == 16'h0f00) lane = 2;
                if (wstrb == 16'hf000) lane = 3;
                if (tag[0] && lane >= 0) begin
                    if (chrq.size() < 16) chrq.push_back(wdata[lane*32 +: 8]);
                    else if (m_drop < 65535) m_drop++;
                end
`ifdef AXI_CONSOLE_EXIT_EN
                if (tag[1] && !m_done && (wstrb == 16'h00ff || wstrb == 16'hff00)) begin
                    v = (wstrb == 16'h00ff) ? wdata[63:0] : wdata[127:64];
                    if (v == PASS_V) begin m_done = 1; m_pass = 1; end
                    else if (v == FAIL_V) m_done = 1;
                end
`else
                v = 0;
`endif
                if (wlast) begin
                    if (byp) consumed = 1;
                    else void'(tagq.pop_front());
                end
            end
        end
        if (aw_h && !consumed) begin
            if (tagq.size() < 4) tagq.push_back(new_tag);
            else m_perr = 1;
        end
    endtask

    task automatic step(input bit awv, input bit awr, input logic [31:0] addr, input logic [3:0] len,
                        input bit wv, input bit wr, input bit last, input logic [15:0] strb,
                        input logic [127:0] data, input bit rdy);
        awvalid = awv; awready = awr; awaddr = addr; awlen = len;
        wvalid = wv; wready = wr; wlast = last; wstrb = strb; wdata = data; chr_ready = rdy;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic do_reset();
        awvalid = 0; wvalid = 0; chr_ready = 0;
        rst = 1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 0;
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        do_reset();
        n_cmp++; if (chr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b need 0", chr_valid); end
        n_cmp++; if (chr_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h need 00", chr_data); end
        n_cmp++; if (chr_level !== 5'd0) begin n_fail++; $display("FAIL rst_level got %0d need 0", chr_level); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drop got %0d need 0", drop_cnt); end
        n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_perr got %b need 0", proto_err); end
        n_cmp++; if ({test_done, test_pass} !== 2'b00) begin n_fail++; $display("FAIL rst_exit got %b%b need 00", test_done, test_pass); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [127:0] d;
        do_reset();
        d = rnd128();
        d[39:32] = 8'h41;
        step(1, 1, CON, 0, 0, 0, 0, 0, 0, 1);
        n_cmp++; if (chr_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre got %b need 0", chr_valid); end
        step(0, 0, 0, 0, 1, 1, 1, 16'h00f0, d, 1);
        n_cmp++; if (chr_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b need 1", chr_valid); end
        n_cmp++; if (chr_data !== 8'h41) begin n_fail++; $display("FAIL single_data got %h need 41", chr_data); end
        n_cmp++; if (chr_level !== 5'd1) begin n_fail++; $display("FAIL single_level got %0d need 1", chr_level); end
        idle(1);
        n_cmp++; if (chr_valid !== 1'b0 || chr_level !== 5'd0) begin n_fail++; $display("FAIL single_drain got %b/%0d need 0/0", chr_valid, chr_level); end
        $display("test_single char 41 done");
    endtask

    task automatic test_bypass();
        logic [127:0] d;
        do_reset();
        d = rnd128();
        d[103:96] = 8'h0a;
        step(1, 1, CON, 0, 1, 1, 1, 16'hf000, d, 0);
        n_cmp++; if (chr_data !== 8'h0a || chr_level !== 5'd1) begin n_fail++; $display("FAIL bypass_char got %h/%0d need 0a/1", chr_data, chr_level); end
        step(1, 1, OTH, 3, 1, 1, 0, 16'h000f, rnd128(), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, i == 2, 16'h000f, rnd128(), 0);
        n_cmp++; if (chr_level !== 5'd1 || chr_data !== 8'h0a) begin n_fail++; $display("FAIL bypass_burst got %h/%0d need 0a/1", chr_data, chr_level); end
        n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL bypass_perr got %b need 0", proto_err); end
        $display("test_bypass done");
    endtask

    task automatic test_fill_drop();
        logic [7:0]   exp_c[16];
        logic [127:0] d;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            d = rnd128();
            if (i < 16) exp_c[i] = d[7:0];
            step(1, 1, CON, 0, 1, 1, 1, 16'h000f, d, 0);
        end
        n_cmp++; if (chr_level !== 5'd16) begin n_fail++; $display("FAIL fill_level got %0d need 16", chr_level); end
        n_cmp++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL fill_drop got %0d need 4", drop_cnt); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (chr_valid !== 1'b1 || chr_data !== exp_c[i]) begin
                n_fail++; $display("FAIL drain_%0d got %b/%h need 1/%h", i, chr_valid, chr_data, exp_c[i]);
            end else $display("drain %0d char %h", i, chr_data);
            idle(1);
        end
        n_cmp++; if (chr_valid !== 1'b0 || chr_level !== 5'd0) begin n_fail++; $display("FAIL fill_empty got %b/%0d need 0/0", chr_valid, chr_level); end
    endtask

    task automatic test_proto();
        do_reset();
        step(0, 0, 0, 0, 1, 1, 1, 16'h000f, rnd128(), 0);
        n_cmp++; if (proto_err !== 1'b1 || chr_level !== 5'd0) begin n_fail++; $display("FAIL orphan_w got %b/%0d need 1/0", proto_err, chr_level); end
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, OTH, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL awq_4 got %b need 0", proto_err); end
        step(1, 1, OTH, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL awq_ovf got %b need 1", proto_err); end
        // Full queue with a same-cycle pop is legal: check on a fresh queue.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, OTH, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, CON, 0, 1, 1, 1, 16'h000f, rnd128(), 0);
        n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL awq_full_pop got %b need 0", proto_err); end
        step(1, 1, OTH, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        model_clear();
        #2;
        n_cmp++; if ({chr_valid, chr_level, drop_cnt, proto_err, test_done, test_pass} !== '0) begin
            n_fail++; $display("FAIL mid_rst got v%b l%0d d%0d p%b t%b%b need all 0", chr_valid, chr_level, drop_cnt, proto_err, test_done, test_pass);
        end
        @(posedge clk); #1; rst = 0; #1;
        step(1, 1, CON, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, CON, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 1, 1, 1, 16'h000f, rnd128(), 0);
        n_cmp++; if (proto_err !== 1'b1 || chr_level !== 5'd0) begin n_fail++; $display("FAIL post_rst_w got %b/%0d need 1/0", proto_err, chr_level); end
        $display("test_proto done");
    endtask

    task automatic test_in_order();
        logic [127:0] d;
        do_reset();
        step(1, 1, OTH, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, CON, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, OTH + 32'h10, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            d = rnd128();
            d[7:0] = 8'h61 + 8'(i);
            step(0, 0, 0, 0, 1, 1, i != 0, 16'h000f, d, 0);
        end
        n_cmp++; if (chr_level !== 5'd1 || chr_data !== 8'h63) begin n_fail++; $display("FAIL in_order got %h/%0d need 63/1", chr_data, chr_level); end
        n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL in_order_perr got %b need 0", proto_err); end
        $display("test_in_order done");
    endtask

    task automatic test_exit();
        logic [127:0] d;
        do_reset();
        d = rnd128();
        d[63:0] = PASS_V;
        step(1, 1, EXT, 0, 1, 1, 1, 16'h00ff, d, 0);
`ifdef AXI_CONSOLE_EXIT_EN
        n_cmp++; if ({test_done, test_pass} !== 2'b11) begin n_fail++; $display("FAIL exit_pass got %b%b need 11", test_done, test_pass); end
`else
        n_cmp++; if ({test_done, test_pass} !== 2'b00) begin n_fail++; $display("FAIL exit_off got %b%b need 00", test_done, test_pass); end
`endif
        d[127:64] = FAIL_V;
        step(1, 1, EXT, 0, 1, 1, 1, 16'hff00, d, 0);
        n_cmp++; if ({test_done, test_pass} !== {m_done, m_pass}) begin n_fail++; $display("FAIL exit_sticky got %b%b need %b%b", test_done, test_pass, m_done, m_pass); end
        n_cmp++; if (chr_level !== 5'd0) begin n_fail++; $display("FAIL exit_nochar got %0d need 0", chr_level); end
        $display("test_exit done");
    endtask

    task automatic test_random();
        logic [15:0] strbs[7];
        logic [31:0] addr;
        bit awv, wv;
        strbs = '{16'h000f, 16'h00f0, 16'h0f00, 16'hf000, 16'h00ff, 16'hff00, 16'h0ff0};
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 3))
                0, 1:    addr = CON | 32'($urandom_range(0, 15));
                2:       addr = EXT;
                default: addr = $urandom();
            endcase
            awv = ($urandom_range(0, 2) == 0) && (tagq.size() < 4 || $urandom_range(0, 40) == 0);
            wv  = ($urandom_range(0, 1) == 0) && (tagq.size() > 0 || awv || $urandom_range(0, 60) == 0);
            step(awv, $urandom_range(0, 3) != 0, addr, ($urandom_range(0, 4) == 0) ? 4'd1 : 4'd0,
                 wv, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 strbs[$urandom_range(0, 6)], rnd128(), (c / 200) % 2 == 1 || $urandom_range(0, 3) == 0);
            n_cmp++; if (chr_valid !== (chrq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b need %b", c, chr_valid, chrq.size() > 0); end
            n_cmp++; if (chr_level !== 5'(chrq.size())) begin n_fail++; $display("FAIL rnd_level cyc %0d got %0d need %0d", c, chr_level, chrq.size()); end
            if (chrq.size() > 0) begin
                n_cmp++; if (chr_data !== chrq[0]) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h need %h", c, chr_data, chrq[0]); end
            end
            n_cmp++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rnd_drop cyc %0d got %0d need %0d", c, drop_cnt, m_drop); end
            n_cmp++; if (proto_err !== m_perr) begin n_fail++; $display("FAIL rnd_perr cyc %0d got %b need %b", c, proto_err, m_perr); end
            n_cmp++; if ({test_done, test_pass} !== {m_done, m_pass}) begin n_fail++; $display("FAIL rnd_exit cyc %0d got %b%b need %b%b", c, test_done, test_pass, m_done, m_pass); end
        end
        $display("test_random done, %0d chars dropped", m_drop);
    endtask

    initial begin
        test_reset();
        test_single();
        test_bypass();
        test_fill_drop();
        test_proto();
        test_in_order();
        test_exit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_console_capture.md
# axi_console_capture

Synthesizable snooper on the 128-bit AXI write path between the CPU BIU (`biu_pad_*`) and `axi_slave128`. It watches AW/W handshakes without driving either channel. It extracts console characters from single-beat writes to the console address and queues them in a character FIFO that a UART or bench drain consumes with a valid/ready handshake. This replaces the bench-side `$write` decoding with a cycle-accurate hardware stage.

## Interface
- `CONSOLE_ADDR`, 32'h01ff_fff0, console line address; compared on bits [31:4].
- `EXIT_ADDR`, 32'h01ff_ffe0, test-exit line address; compared on bits [31:4]. Used only with the macro below.
- `CHR_DEPTH`, 16, character FIFO depth; power of two, ≥2.
- `AWQ_DEPTH`, 4, pending-AW tag queue depth; power of two, ≥2.
- `clk  in  1  clock (CPU/AXI clock)`
- `rst  in  1  asynchronous, active-high reset`
- `awvalid, awready  in  1  AW handshake (snooped)`
- `awaddr  in  32  write address`
- `awlen  in  4  burst length − 1`
- `wvalid, wready, wlast  in  1  W handshake and last beat (snooped)`
- `wdata  in  128  write data`
- `wstrb  in  16  write strobes`
- `chr_valid  out  1  character available`
- `chr_data  out  8  character at FIFO head`
- `chr_ready  in  1  consumer accepts character`
- `chr_level  out  $clog2(CHR_DEPTH)+1  FIFO occupancy`
- `drop_cnt  out  16  characters dropped on full FIFO; saturating`
- `proto_err  out  1  sticky: AW queue overflow or W beat with no AW`
- `test_done, test_pass  out  1  exit status (macro-dependent)`

## Operation
- AW handshake (`awvalid&awready`) produces a tag: `hit_con = (awaddr[31:4]==CONSOLE_ADDR[31:4]) && awlen==0`, plus `hit_exit`, formed the same way from EXIT_ADDR. The tag is pushed into the AWQ.
- W handshake (`wvalid&wready`) belongs to the AWQ head tag. If the AWQ is empty and an AW handshake occurs in the same cycle, that AW's tag is used directly (bypass) and is not pushed when this beat is its `wlast`.
- If the AWQ is empty and there is no same-cycle AW, the W beat is ignored and `proto_err` is set.
- A W handshake with `wlast` pops the head tag. A push and a pop in the same cycle with a full AWQ is legal.
- An AW push into a full AWQ that is not popped the same cycle drops the tag and sets `proto_err`.
- Console beat (tag `hit_con`), lane decode on exact `wstrb` values:
  - 16'h000f → `wdata[7:0]`
  - 16'h00f0 → `wdata[39:32]`
  - 16'h0f00 → `wdata[71:64]`
  - 16'hf000 → `wdata[103:96]`
  - any other strobe value: beat discarded, no error.
- Character FIFO:
  - Push when not full, or when full and popping in the same cycle.
  - Otherwise the character is dropped and `drop_cnt` increments, saturating at 16'hffff.
  - Pop on `chr_valid&chr_ready`.
  - `chr_data` is valid only while `chr_valid` is high, and is stable until popped.
- Pointers wrap modulo CHR_DEPTH, with an extra MSB for full/empty detection.
- Reset mid-burst clears the AWQ, the FIFO and the counters. W beats after reset that belong to pre-reset AWs set `proto_err`.

## Timing
- Reset values: `chr_valid`=0, `chr_data`=0, `chr_level`=0, `drop_cnt`=0, `proto_err`=0, `test_done`=0, `test_pass`=0.
- Capture latency: the character is captured on the W handshake edge at cycle N. `chr_valid`=1 and `chr_level` are updated from cycle N+1.
- Back-to-back console beats, one per cycle, are all captured while space remains.
- `chr_valid` stays high while the FIFO is non-empty. Drain throughput is one character per cycle.
- Simultaneous push and pop: `chr_level` is unchanged and the head advances.
- `proto_err` and `drop_cnt` update at N+1 after the offending handshake.

## Configuration
- Macro: `AXI_CONSOLE_EXIT_EN`.
- Defined:
  - A beat with tag `hit_exit` and `wstrb==16'h00ff` compares `wdata[63:0]`; with `wstrb==16'hff00` it compares `wdata[127:64]`.
  - Value 64'h444333222 → `test_done`=1, `test_pass`=1.
  - Value 64'h2382348720 → `test_done`=1, `test_pass`=0.
  - Both outputs are registered (valid at N+1) and sticky until reset. The first exit write wins.
- Undefined: `hit_exit` logic is removed; `test_done` and `test_pass` are tied 0. Ports remain.

## Test plan
- AW 0x01ff_fff0, awlen 0, then W with wstrb 16'h00f0, wdata[39:32]=8'h41, chr_ready=1 → `chr_valid` pulses one cycle at N+1 with `chr_data`=8'h41; `chr_level` goes 0→1→0.
- Same-cycle AW+W to the console address with wstrb 16'hf000, wdata[103:96]=8'h0a → captured as 8'h0a. An AW+W to 0x8000_0000 with a 4-beat burst → nothing captured.
- chr_ready=0, then 20 console writes with CHR_DEPTH=16 → `chr_level`=16 and `drop_cnt`=4. After draining, the 16 characters come out in write order.
- A W beat with no AW → `proto_err`=1 and nothing captured. 5 AWs without W beats (AWQ_DEPTH=4) → `proto_err` set; assert `rst` mid-sequence → all outputs return to reset values.
- AWs issued as non-console 2-beat, then console, then non-console, followed by 4 W beats → only the 3rd W beat is decoded, proving in-order tag tracking.
- With the macro defined, write 64'h444333222 to EXIT_ADDR (wstrb 16'h00ff) → `test_done`=1, `test_pass`=1. A later write of 64'h2382348720 → no change. Without the macro → both outputs stay 0.
